sniffer_match_controller: RTL



---
 rtl/sniffer_match_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sniffer_match_controller.sv
// sniffer_match_controller
//   Sequences comparator register load, per-packet input-FIFO fill,
//   comparator drain and match evaluation for NUM_COMP comparator channels.
//   Keeps saturating statistics of evaluated, hitting and dropped packets.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   match           per-comparator match flags
//   match_en        per-channel enable mask (used in EVAL)
//   require_all     0: any enabled channel hits, 1: all enabled must match
//   update_done     comparator registers loaded
//   ready/eop/error MAC packet start / end of packet / packet error
//   rdempty         input FIFO empty
//   rdreq           input FIFO read request
//   inc_addr        address buffer increment
//   addr            Avalon slave select (comparator register load)
//   clear           clear comparator match flags
//   match_vec       latched (match & match_en) of last evaluated packet
//   pkt_count       packets reaching EVAL
//   match_count     packets that hit
//   drop_count      packets dropped (error or timeout)
//   busy            high in every state except IDLE
module sniffer_match_controller #(
  parameter int NUM_COMP       = 4,
  parameter int COMP_LATENCY   = 4,
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COMP-1:0] match,
  input  logic [NUM_COMP-1:0] match_en,
  input  logic                require_all,
  input  logic                update_done,
  input  logic                ready,
  input  logic                eop,
  input  logic                error,
  input  logic                rdempty,
  output logic                rdreq,
  output logic                inc_addr,
  output logic                addr,
  output logic                clear,
  output logic [NUM_COMP-1:0] match_vec,
  output logic [CNT_W-1:0]    pkt_count,
  output logic [CNT_W-1:0]    match_count,
  output logic [CNT_W-1:0]    drop_count,
  output logic                busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DW = (COMP_LATENCY > 2) ? $clog2(COMP_LATENCY) : 1;
  localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0]    DRAIN_LD  = DW'(COMP_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [3:0] {
    S_RESET,
    S_LOAD_COMP_REG,
    S_IDLE,
    S_LOAD_INPUT_FIFO,
    S_COMPARE,
    S_DRAIN,
    S_EVAL,
    S_LOAD_MEMORY,
    S_ERROR
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [TW-1:0]       tmo_cnt;
  logic [DW-1:0]       drain_cnt;
  logic [NUM_COMP-1:0] masked;
  logic                hit;
  logic                tmo_hit;

  always_comb begin
    masked  = match & match_en;
    // An empty enable mask never hits, even in AND mode where m == match_en.
    hit     = require_all ? ((masked == match_en) && (|match_en)) : (|masked);
    tmo_hit = (tmo_cnt == TMO_LAST);
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RESET:           next_state = S_LOAD_COMP_REG;
      S_LOAD_COMP_REG:   if (update_done) next_state = S_IDLE;
      S_IDLE:            if (ready) next_state = S_LOAD_INPUT_FIFO;
      S_LOAD_INPUT_FIFO: begin
        // error wins over a simultaneous eop
        if (error)        next_state = S_ERROR;
        else if (eop)     next_state = S_COMPARE;
        else if (tmo_hit) next_state = S_ERROR;
      end
      S_COMPARE:         if (rdempty) next_state = S_DRAIN;
      S_DRAIN:           if (drain_cnt == '0) next_state = S_EVAL;
      S_EVAL:            next_state = hit ? S_LOAD_MEMORY : S_IDLE;
      S_LOAD_MEMORY:     next_state = S_IDLE;
      S_ERROR:           if (eop || tmo_hit) next_state = S_IDLE;
      default:           next_state = S_RESET;
    endcase
  end

  // Outputs are decoded from next_state so they line up with the state
  // being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET;
      tmo_cnt     <= '0;
      drain_cnt   <= '0;
      rdreq       <= 1'b0;
      inc_addr    <= 1'b0;
      addr        <= 1'b0;
      clear       <= 1'b0;
      busy        <= 1'b0;
      match_vec   <= '0;
      pkt_count   <= '0;
      match_count <= '0;
      drop_count  <= '0;
    end else begin
      state    <= next_state;
      rdreq    <= (next_state == S_LOAD_INPUT_FIFO);
      inc_addr <= (next_state == S_LOAD_MEMORY);
      addr     <= (next_state == S_LOAD_COMP_REG);
      clear    <= (next_state == S_IDLE) || (next_state == S_EVAL);
      busy     <= (next_state != S_IDLE);

      // The timeout comparison always fires before the counter can wrap.
      if (next_state != state)
        tmo_cnt <= '0;
      else if (state == S_LOAD_INPUT_FIFO || state == S_ERROR)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;

      if (next_state == S_DRAIN && state != S_DRAIN)
        drain_cnt <= DRAIN_LD;
      else if (state == S_DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 1'b1;

      if (state == S_EVAL) begin
        match_vec <= masked;
        if (pkt_count != CNT_MAX)
          pkt_count <= pkt_count + 1'b1;
        if (hit && match_count != CNT_MAX)
          match_count <= match_count + 1'b1;
      end

      // Only the entry into ERROR counts; leaving it on timeout does not.
      if (state == S_LOAD_INPUT_FIFO && next_state == S_ERROR &&
          drop_count != CNT_MAX)
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule
